restoring_divider16: RTL and testbench



---
 rtl/restoring_divider16_pkg.sv | 16 +
 rtl/restoring_divider16_if.sv | 26 ++
 rtl/restoring_divider16_trial_subtractor17.sv | 16 +
 rtl/restoring_divider16.sv | 140 ++++++++++++++
 tb/tb_restoring_divider16.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/restoring_divider16_pkg.sv
// Shared ALU definitions for the multi-cycle restoring divider.
// The divider state encoding and iteration constants live here.
package restoring_divider16_pkg;

  localparam int          DIV_WIDTH     = 16;
  localparam int          DIV_ITER      = 16;
  localparam int          DIV_CNT_W     = $clog2(DIV_ITER);
  localparam logic [15:0] DIV_ZERO_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/restoring_divider16_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
// master = requester (ALU control), slave = divider.
interface restoring_divider16_if #(
  parameter int WIDTH = 16
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );

endinterface

// File: rtl/restoring_divider16_trial_subtractor17.sv
// Combinational 17-bit trial subtract; borrow_o is bit 16 of the difference.
// Reuse point for the select-adder cells of the datapath.
module trial_subtractor17 (
  input  logic [16:0] minuend_i,
  input  logic [16:0] subtrahend_i,
  output logic [15:0] diff_o,
  output logic        borrow_o
);

  logic [16:0] diff_full;

  assign diff_full = minuend_i - subtrahend_i;
  assign diff_o    = diff_full[15:0];
  assign borrow_o  = diff_full[16];

endmodule

// File: rtl/restoring_divider16.sv
// Unsigned 16-bit restoring divider, one quotient bit per cycle.
// Define DIVIDER_ZERO_DETECT_EN to short-circuit division by zero.
module restoring_divider16
  import restoring_divider16_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  restoring_divider16_if.slave  div_if
);

  localparam logic [1:0]           S_IDLE   = DIV_IDLE;
  localparam logic [1:0]           S_RUN    = DIV_RUN;
  localparam logic [1:0]           S_DONE   = DIV_DONE;
  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(DIV_ITER - 1);

  logic [1:0]           state_q, state_d;
  // The 17th partial-remainder bit is always zero once a step settles, so
  // only the low WIDTH bits are stored; it is rebuilt inside the trial value.
  logic [WIDTH-1:0]     r_q, r_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     d_q, d_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     quot_q, quot_d;
  logic [WIDTH-1:0]     rem_q, rem_d;

  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     diff;
  logic                 borrow;
  logic [WIDTH-1:0]     r_next;
  logic [WIDTH-1:0]     q_next;
  logic                 accept;

  assign trial = {r_q, q_q[WIDTH-1]};

  trial_subtractor17 u_sub (
    .minuend_i    (trial),
    .subtrahend_i ({1'b0, d_q}),
    .diff_o       (diff),
    .borrow_o     (borrow)
  );

  assign r_next = borrow ? trial[WIDTH-1:0] : diff;
  assign q_next = {q_q[WIDTH-2:0], ~borrow};
  assign accept = (state_q != S_RUN) && div_if.start;

`ifdef DIVIDER_ZERO_DETECT_EN
  logic dz_q, dz_d;
`endif

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path
    // through the case statement leaves one unassigned (no latches).
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef DIVIDER_ZERO_DETECT_EN
    dz_d    = dz_q;
`endif

    case (state_q)
      S_RUN: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          quot_d  = q_next;
          rem_d   = r_next;
        end
      end
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_RUN;
          r_d     = '0;
          q_d     = div_if.dividend;
          d_d     = div_if.divisor;
          cnt_d   = '0;
`ifdef DIVIDER_ZERO_DETECT_EN
          dz_d    = 1'b0;
          if (div_if.divisor == '0) begin
            state_d = S_DONE;
            quot_d  = DIV_ZERO_QUOT;
            rem_d   = div_if.dividend;
            dz_d    = 1'b1;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the datapath registers are reset along with the FSM; they are few
  // and the result outputs must read zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

`ifdef DIVIDER_ZERO_DETECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dz_q <= 1'b0;
    else     dz_q <= dz_d;
  end

  assign div_if.div_zero = dz_q;
`else
  assign div_if.div_zero = 1'b0;
`endif

  assign div_if.busy      = (state_q == S_RUN);
  assign div_if.done      = (state_q == S_DONE);
  assign div_if.quotient  = quot_q;
  assign div_if.remainder = rem_q;

endmodule

// File: tb/tb_restoring_divider16.sv
// Scoreboard bench for restoring_divider16: the driver queues expected results,
// a negedge monitor pops one entry per done pulse and checks value and timing.
module tb_restoring_divider16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edges = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          due;
  } exp_t;

  exp_t sb[$];

  restoring_divider16_if #(.WIDTH(16)) div_if ();

  restoring_divider16 dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (div_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called on a negedge; start is sampled at the following posedge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic q_exp,
                       input logic [15:0] q, input logic [15:0] r);
    exp_t e;
    int   lat_edges;
    bit   zero_fast;
`ifdef DIVIDER_ZERO_DETECT_EN
    zero_fast = (b == 16'd0);
`else
    zero_fast = 1'b0;
`endif
    // done is visible 16 edges after the accept edge (cycle N+17), or right
    // after it when the zero short-cut applies (cycle N+1).
    lat_edges = zero_fast ? 1 : 17;
    div_if.start    = 1'b1;
    div_if.dividend = a;
    div_if.divisor  = b;
    if (q_exp) begin
      e.a   = a;
      e.b   = b;
      e.q   = q;
      e.r   = r;
      e.dz  = zero_fast;
      e.due = edges + lat_edges;
      sb.push_back(e);
    end
    @(negedge clk);
    div_if.start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (div_if.done) break;
      @(negedge clk);
    end
    check("wait_done", {31'd0, div_if.done}, 32'd1);
  endtask

  // Monitor: one scoreboard entry per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("busy_and_done", {31'd0, div_if.busy & div_if.done}, 32'd0);
      if (div_if.done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, {31'd0, div_if.busy});
        end else begin
          e = sb.pop_front();
          check("quotient", {16'd0, div_if.quotient}, {16'd0, e.q});
          check("remainder", {16'd0, div_if.remainder}, {16'd0, e.r});
          check("div_zero", {31'd0, div_if.div_zero}, {31'd0, e.dz});
          check("latency", edges, e.due);
          if (e.b != 16'd0) begin
            check("identity", 32'(div_if.quotient) * 32'(e.b) + 32'(div_if.remainder), {16'd0, e.a});
            check("rem_lt_div", {31'd0, div_if.remainder < e.b}, 32'd1);
          end
        end
      end
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [15:0] ra, rb;
    div_if.start    = 1'b0;
    div_if.dividend = '0;
    div_if.divisor  = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, div_if.busy}, 32'd0);
    check("rst_done", {31'd0, div_if.done}, 32'd0);
    check("rst_quotient", {16'd0, div_if.quotient}, 32'd0);
    check("rst_remainder", {16'd0, div_if.remainder}, 32'd0);
    check("rst_div_zero", {31'd0, div_if.div_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 100 / 7
    issue(16'd100, 16'd7, 1'b1, 16'd14, 16'd2);
    wait_done();
    @(negedge clk);

    // 0xFFFF / 1, then 5 / 9 issued during the done cycle
    issue(16'hFFFF, 16'd1, 1'b1, 16'hFFFF, 16'd0);
    wait_done();
    issue(16'd5, 16'd9, 1'b1, 16'd0, 16'd5);
    wait_done();
    @(negedge clk);

    // Divide by zero
    issue(16'h1234, 16'd0, 1'b1, 16'hFFFF, 16'h1234);
    wait_done();
    @(negedge clk);
    check("dz_clear_busy", {31'd0, div_if.busy}, 32'd0);

    // start in RUN is ignored, operand changes after accept have no effect
    issue(16'd200, 16'd10, 1'b1, 16'd20, 16'd0);
    repeat (4) @(negedge clk);
    div_if.start    = 1'b1;
    div_if.dividend = 16'd9;
    div_if.divisor  = 16'd3;
    @(negedge clk);
    div_if.start = 1'b0;
    wait_done();
    repeat (25) @(negedge clk);

    // Reset at RUN cycle 8 aborts, then 50 / 6
    issue(16'd1000, 16'd3, 1'b0, 16'd0, 16'd0);
    repeat (7) @(negedge clk);
    check("pre_rst_busy", {31'd0, div_if.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, div_if.busy}, 32'd0);
    check("arst_done", {31'd0, div_if.done}, 32'd0);
    check("arst_quotient", {16'd0, div_if.quotient}, 32'd0);
    check("arst_remainder", {16'd0, div_if.remainder}, 32'd0);
    check("arst_div_zero", {31'd0, div_if.div_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_idle", {30'd0, div_if.busy, div_if.done}, 32'd0);
    issue(16'd50, 16'd6, 1'b1, 16'd8, 16'd2);
    wait_done();
    @(negedge clk);

    // Boundary vectors, back to back
    vecs.push_back('{16'd0,     16'd5,     16'd0,     16'd0});
    vecs.push_back('{16'hFFFF,  16'hFFFF,  16'd1,     16'd0});
    vecs.push_back('{16'd7,     16'hFFFF,  16'd0,     16'd7});
    vecs.push_back('{16'h8000,  16'd3,     16'h2AAA,  16'd2});
    vecs.push_back('{16'hFFFE,  16'hFFFF,  16'd0,     16'hFFFE});
    vecs.push_back('{16'd0,     16'd0,     16'hFFFF,  16'd0});
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, 1'b1, vecs[i].q, vecs[i].r);
      wait_done();
    end
    @(negedge clk);

    // Random operand pairs, back to back, against the reference model
    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 16'd0;
        1:       rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      if (rb == 16'd0) issue(ra, rb, 1'b1, 16'hFFFF, ra);
      else             issue(ra, rb, 1'b1, ra / rb, ra % rb);
      wait_done();
    end
    repeat (3) @(negedge clk);

    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
